seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-sequence detector; next generation of the team's single-bit Mealy detector FSM.
- Generalised from a fixed 3-state machine to a PATTERN_W-bit pattern that is loadable at runtime.
- Adds overlap and non-overlap modes, a qualifying valid strobe, and both a Mealy output and a registered output.
- Sits after a serial deserialiser/sampler; feeds control logic that needs frame-marker or sync-word detection.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011, reset-default pattern; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history flushed after each match.
- CNT_W, 8, match counter width; used only with SEQDET_CNT_EN.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- cfg_load  in  1  load cfg_pattern into the pattern register.
- cfg_pattern  in  PATTERN_W  new pattern; MSB first on the wire.
- in_valid  in  1  qualifies in; in is ignored when this is low.
- in  in  1  serial data bit.
- match  out  1  Mealy match; combinational from current state, in_valid and in.
- match_q  out  1  match registered; one-cycle delayed copy.
- primed  out  1  history holds at least PATTERN_W-1 valid bits.
- match_cnt  out  CNT_W  saturating match count; present only with SEQDET_CNT_EN.

Behaviour:
- State:
  - hist: PATTERN_W-1 bits of shift history.
  - fill: count 0..PATTERN_W-1, saturates at PATTERN_W-1.
  - pat: PATTERN_W bits.
- Reset (reset==0 at a clk edge):
  - hist=0, fill=0, pat=PATTERN, match_q=0, match_cnt=0.
  - match is forced to 0 while reset is low.
- Priority on each clk edge: reset > cfg_load > in_valid.
- cfg_load=1:
  - pat<=cfg_pattern; hist and fill cleared; match_q<=0.
  - match is forced to 0 in that cycle, even if in_valid is high.
  - The in bit presented in that cycle is discarded.
- match = in_valid & ~cfg_load & reset & (fill==PATTERN_W-1) & ({hist,in}==pat).
  - Zero latency: asserts in the same cycle as the completing bit.
- Shift on in_valid=1 with no cfg_load:
  - hist<={hist[PATTERN_W-3:0],in}; fill<=min(fill+1, PATTERN_W-1).
  - For PATTERN_W=2, hist is a single bit and hist<=in.
- OVERLAP=0 with match=1: hist<=0 and fill<=0 instead of shifting, so the next match needs PATTERN_W fresh bits.
- OVERLAP=1 with match=1: shift proceeds normally, so the pattern tail can seed the next match.
- in_valid=0: hist, fill and pat hold; match=0.
  - Gaps of any length are transparent to detection.
- match_q<=match every cycle; it is a one-cycle pulse per match.
- primed = (fill==PATTERN_W-1); it is a registered state decode.
- Reset mid-sequence discards all partial history; the post-reset sequence starts fresh.
- Width rules: all compares are PATTERN_W bits wide; no sign extension.

Optional Feature:
- Macro: SEQDET_CNT_EN.
- Defined:
  - match_cnt port and counter are present.
  - Counter increments on each match=1 cycle and saturates at 2^CNT_W-1; it never wraps.
  - Counter is cleared by reset and by cfg_load.
- Undefined:
  - Port and counter are absent; no counter logic is generated.
  - All other behaviour is identical.

Test Plan:
- PATTERN=1011, OVERLAP=1, valid stream 1,0,1,1,0,1,1 -> match high on bit 4 and bit 7; match_q high one cycle after each.
- PATTERN=1011, OVERLAP=0, same stream -> match only on bit 4; primed drops to 0 the cycle after the match.
- PATTERN=101, stream 1,(in_valid=0 for 3 cycles),0,1 -> match on the final bit; hist is unchanged during the gap.
- Stream 1,0,1 (PATTERN=1011, 3 bits in), then reset low for 1 cycle, then 1 -> no match; fill=1 after the post-reset bit.
- cfg_load with cfg_pattern=0110 while in_valid=1 and in completes 1011 -> match=0 that cycle; then stream 0,1,1,0 -> match on bit 4.
- SEQDET_CNT_EN, CNT_W=2, PATTERN=11, OVERLAP=1, eight consecutive 1s -> match_cnt reaches 3 and holds at 3 (7 matches).

Source files
------------

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control.
// Optional saturating match counter enabled by defining SEQDET_CNT_EN.
module seq_detector_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_load,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic                 in_valid,
    input  logic                 in,
    output logic                 match,
    output logic                 match_q,
    output logic                 primed
`ifdef SEQDET_CNT_EN
    ,
    output logic [CNT_W-1:0]     match_cnt
`endif
);

    localparam int HW = PATTERN_W - 1;
    localparam int FW = $clog2(PATTERN_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(HW);

    if (PATTERN_W < 2 || PATTERN_W > 32 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: illegal parameter value");
    end

    logic [HW-1:0]        hist;
    logic [HW-1:0]        hist_d;
    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_d;
    logic [PATTERN_W-1:0] pat;
    logic [PATTERN_W-1:0] pat_d;
    logic [PATTERN_W-1:0] win;

    assign win    = {hist, in};
    assign primed = (fill == FILL_MAX);

    // Mealy match: completing bit compared against the live pattern.
    always_comb begin
        match = in_valid & ~cfg_load & reset & primed & (win == pat);
    end

    // Next history/fill/pattern: load beats shift; non-overlap flushes.
    always_comb begin
        hist_d = hist;
        fill_d = fill;
        pat_d  = pat;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            if (match && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = win[HW-1:0];
                if (!primed) begin
                    fill_d = fill + 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist    <= '0;
            fill    <= '0;
            pat     <= PATTERN;
            match_q <= 1'b0;
        end else begin
            hist    <= hist_d;
            fill    <= fill_d;
            pat     <= pat_d;
            match_q <= match;
        end
    end

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] cnt_d;

    // Saturating count of match cycles; cleared on pattern load.
    always_comb begin
        cnt_d = match_cnt;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (match && (match_cnt != '1)) begin
            cnt_d = match_cnt + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_cnt <= '0;
        end else begin
            match_cnt <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random
// stimulus checked against a bit-list reference model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_load = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_b = 1'b0;
    logic [3:0] cfg4 = 4'b1011;
    logic [2:0] cfg3 = 3'b101;
    logic [1:0] cfg2 = 2'b11;
    logic       mo [4];
    logic       mqo [4];
    logic       pro [4];
`ifdef SEQDET_CNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [7:0] cnt2;
    logic [1:0] cnt3;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_detector_param #(
        .PATTERN_W(4), .PATTERN(4'b1011),
        .OVERLAP(1'b1), .CNT_W(8)
    ) u_ov (
        .clk(clk), .reset(reset), .cfg_load(cfg_load),
        .cfg_pattern(cfg4), .in_valid(in_valid), .in(in_b),
        .match(mo[0]), .match_q(mqo[0]), .primed(pro[0])
`ifdef SEQDET_CNT_EN
        , .match_cnt(cnt0)
`endif
    );

    seq_detector_param #(
        .PATTERN_W(4), .PATTERN(4'b1011),
        .OVERLAP(1'b0), .CNT_W(8)
    ) u_nov (
        .clk(clk), .reset(reset), .cfg_load(cfg_load),
        .cfg_pattern(cfg4), .in_valid(in_valid), .in(in_b),
        .match(mo[1]), .match_q(mqo[1]), .primed(pro[1])
`ifdef SEQDET_CNT_EN
        , .match_cnt(cnt1)
`endif
    );

    seq_detector_param #(
        .PATTERN_W(3), .PATTERN(3'b101),
        .OVERLAP(1'b1), .CNT_W(8)
    ) u_w3 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load),
        .cfg_pattern(cfg3), .in_valid(in_valid), .in(in_b),
        .match(mo[2]), .match_q(mqo[2]), .primed(pro[2])
`ifdef SEQDET_CNT_EN
        , .match_cnt(cnt2)
`endif
    );

    seq_detector_param #(
        .PATTERN_W(2), .PATTERN(2'b11),
        .OVERLAP(1'b1), .CNT_W(2)
    ) u_w2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load),
        .cfg_pattern(cfg2), .in_valid(in_valid), .in(in_b),
        .match(mo[3]), .match_q(mqo[3]), .primed(pro[3])
`ifdef SEQDET_CNT_EN
        , .match_cnt(cnt3)
`endif
    );

    // Reference model: list of the most recent valid bits since the
    // last flush, oldest first, capped at width-1 entries.
    int          mw [4];
    bit          movl [4];
    logic [31:0] mdef [4];
    logic [31:0] mp [4];
    int          ecap [4];
    bit          hb [4][32];
    int          hn [4];
    bit          eq [4];
    int          ecnt [4];
    bit          em [4];

    function automatic bit hit(input int i, input bit b);
        if (hn[i] < mw[i] - 1) return 1'b0;
        for (int k = 0; k < mw[i] - 1; k++) begin
            if (hb[i][k] != mp[i][mw[i]-1-k]) return 1'b0;
        end
        return b == mp[i][0];
    endfunction

    function automatic void push(input int i, input bit b);
        if (hn[i] < mw[i] - 1) begin
            hb[i][hn[i]] = b;
            hn[i]++;
        end else begin
            for (int k = 0; k < mw[i] - 2; k++) hb[i][k] = hb[i][k+1];
            hb[i][mw[i]-2] = b;
        end
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 4; i++) begin
            hn[i] = 0;
            mp[i] = mdef[i];
            eq[i] = 1'b0;
            ecnt[i] = 0;
        end
    endfunction

    task automatic drive(input logic r, input logic ld,
                         input logic v, input logic b);
        @(negedge clk);
        reset = r;
        cfg_load = ld;
        in_valid = v;
        in_b = b;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (mo[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_match[%0d]: got %b exp 0", i, mo[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (pro[i] !== 1'b0 || mqo[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_state[%0d]: primed %b match_q %b exp 0 0",
                         i, pro[i], mqo[i]);
            end
        end
`ifdef SEQDET_CNT_EN
        n_chk++;
        if (cnt0 !== 8'd0 || cnt3 !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_cnt: got %0d/%0d exp 0/0", cnt0, cnt3);
        end
`endif
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1101101;
        logic [6:0] e0 = 7'b1001000;
        logic [6:0] e2 = 7'b0100100;
        logic [6:0] p0 = 7'b1111000;
        logic       prev = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b1, s[i]);
            n_chk++;
            if (mo[0] !== e0[i] || mqo[0] !== prev) begin
                n_fail++;
                $display("FAIL ovl_bit%0d: match %b q %b exp %b %b",
                         i + 1, mo[0], mqo[0], e0[i], prev);
            end
            n_chk++;
            if (pro[0] !== p0[i]) begin
                n_fail++;
                $display("FAIL ovl_primed%0d: got %b exp %b",
                         i + 1, pro[0], p0[i]);
            end
            n_chk++;
            if (mo[2] !== e2[i]) begin
                n_fail++;
                $display("FAIL w3_bit%0d: got %b exp %b",
                         i + 1, mo[2], e2[i]);
            end
            prev = e0[i];
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        n_chk++;
        if (mqo[0] !== 1'b1 || mo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovl_tail: match %b q %b exp 0 1", mo[0], mqo[0]);
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] s = 7'b1101101;
        logic [6:0] e1 = 7'b0001000;
        logic [6:0] p1 = 7'b0001000;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b1, s[i]);
            n_chk++;
            if (mo[1] !== e1[i] || pro[1] !== p1[i]) begin
                n_fail++;
                $display("FAIL novl_bit%0d: match %b primed %b exp %b %b",
                         i + 1, mo[1], pro[1], e1[i], p1[i]);
            end
        end
    endtask

    task automatic test_gap();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'($urandom));
            n_chk++;
            if (mo[2] !== 1'b0 || pro[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL gap%0d: match %b primed %b exp 0 0",
                         i, mo[2], pro[2]);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (mo[2] !== 1'b1 || pro[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_final: match %b primed %b exp 1 1",
                     mo[2], pro[2]);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (mo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_force: got %b exp 0", mo[0]);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (mo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_first: got %b exp 0", mo[0]);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (pro[0] !== 1'b0 || mqo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_fill: primed %b q %b exp 0 0",
                     pro[0], mqo[0]);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (pro[0] !== 1'b0 || mo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_bit3: primed %b match %b exp 0 0",
                     pro[0], mo[0]);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (mo[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_fresh: got %b exp 1", mo[0]);
        end
    endtask

    task automatic test_cfg_load();
        logic [3:0] s = 4'b0110;
        logic [3:0] e = 4'b1000;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cfg4 = 4'b0110;
        cfg3 = 3'b101;
        cfg2 = 2'b11;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_chk++;
        if (mo[0] !== 1'b0 || mo[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_force: got %b %b exp 0 0", mo[0], mo[1]);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, s[3-i]);
            n_chk++;
            if (mo[0] !== e[i] || mo[1] !== e[i]) begin
                n_fail++;
                $display("FAIL load_bit%0d: got %b %b exp %b",
                         i + 1, mo[0], mo[1], e[i]);
            end
        end
    endtask

    task automatic test_counter();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            n_chk++;
            if (mo[3] !== (k > 0)) begin
                n_fail++;
                $display("FAIL cnt_match%0d: got %b exp %b",
                         k + 1, mo[3], k > 0);
            end
`ifdef SEQDET_CNT_EN
            n_chk++;
            if (int'(cnt3) !== ((k < 2) ? 0 : ((k - 1 > 3) ? 3 : k - 1))) begin
                n_fail++;
                $display("FAIL cnt_val%0d: got %0d", k + 1, cnt3);
            end
`endif
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SEQDET_CNT_EN
        n_chk++;
        if (cnt3 !== 2'd3) begin
            n_fail++;
            $display("FAIL cnt_sat: got %0d exp 3", cnt3);
        end
        cfg2 = 2'b11;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (cnt3 !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_load_clr: got %0d exp 0", cnt3);
        end
`endif
    endtask

    task automatic test_random();
        logic r, ld, v, b;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        mdl_reset();
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(99) != 0);
            ld = ($urandom_range(39) == 0);
            v  = ($urandom_range(3) != 0);
            b  = 1'($urandom);
            if (ld) begin
                cfg4 = 4'($urandom);
                cfg3 = 3'($urandom);
                cfg2 = 2'($urandom);
            end
            drive(r, ld, v, b);
            for (int i = 0; i < 4; i++) begin
                em[i] = r && !ld && v && hit(i, b);
                n_chk++;
                if (mo[i] !== em[i] || mqo[i] !== eq[i] ||
                    pro[i] !== (hn[i] == mw[i] - 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_dut%0d: m %b q %b p %b exp %b %b %b",
                             n, i, mo[i], mqo[i], pro[i],
                             em[i], eq[i], hn[i] == mw[i] - 1);
                end
            end
`ifdef SEQDET_CNT_EN
            n_chk++;
            if (int'(cnt0) !== ecnt[0] || int'(cnt3) !== ecnt[3]) begin
                n_fail++;
                $display("FAIL rnd%0d_cnt: got %0d %0d exp %0d %0d",
                         n, cnt0, cnt3, ecnt[0], ecnt[3]);
            end
`endif
            for (int i = 0; i < 4; i++) begin
                if (!r) begin
                    hn[i] = 0;
                    mp[i] = mdef[i];
                    ecnt[i] = 0;
                end else if (ld) begin
                    hn[i] = 0;
                    ecnt[i] = 0;
                    case (i)
                        0, 1: mp[i] = {28'd0, cfg4};
                        2: mp[i] = {29'd0, cfg3};
                        default: mp[i] = {30'd0, cfg2};
                    endcase
                end else if (v) begin
                    if (em[i] && !movl[i]) hn[i] = 0;
                    else push(i, b);
                    if (em[i] && ecnt[i] < ecap[i]) ecnt[i]++;
                end
                eq[i] = em[i];
            end
        end
    endtask

    initial begin
        mw   = '{4, 4, 3, 2};
        movl = '{1'b1, 1'b0, 1'b1, 1'b1};
        mdef = '{32'b1011, 32'b1011, 32'b101, 32'b11};
        ecap = '{255, 255, 255, 3};
        mdl_reset();
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gap();
        test_reset_mid();
        test_cfg_load();
        test_counter();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
